// File: rtl/selftest_pkg.sv
// Shared definitions for the on-chip self-test sequencer and related stimulus blocks.
//   state_t    : sequencer FSM encoding
//   MODE_*     : run-mode encodings sampled at start (any other value behaves as MODE_EXH)
//   LFSR_POLY  : Galois feedback mask for the 32-bit pseudorandom generator
package selftest_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COOL,
    ST_SETTLE,
    ST_DONE,
    ST_FAIL
  } state_t;

  localparam logic [1:0] MODE_EXH  = 2'b00;
  localparam logic [1:0] MODE_RAND = 2'b01;
  localparam logic [1:0] MODE_BOTH = 2'b10;

  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

endpackage

// File: rtl/lfsr32_step.sv
// Combinational next-state function of a 32-bit Galois LFSR.
//   state      in  32  current LFSR value
//   next_state out 32  value after one shift: (state >> 1) ^ (state[0] ? LFSR_POLY : 0)
module lfsr32_step
  import selftest_pkg::*;
(
  input  logic [31:0] state,
  output logic [31:0] next_state
);

  assign next_state = (state >> 1) ^ (state[0] ? LFSR_POLY : 32'h0);

endmodule

// File: rtl/selftest_sequencer.sv
// Self-test controller: walks a combinational DUT through exhaustive and/or
// pseudorandom vectors, giving each vector a cooldown window (input forced to 0)
// and a settle window, then compares the DUT output against a reference model.
// The first mismatch stops the run and the failing vector is held.
//   clk, rst_n      clock, asynchronous active-low reset
//   start, mode     one-cycle run request; mode 00 exh, 01 rand, 10 exh+rand, 11 = 00
//   comp_in[_valid] vector driven to DUT and reference model
//   verify, comp_out reference and DUT outputs
//   busy, done, fail run status (done/fail sticky until next start)
//   fail_vec/expected/got  snapshot taken at the failing compare
//   vec_count       passing vectors in this run, saturating
module selftest_sequencer
  import selftest_pkg::*;
#(
  parameter int          INBITS     = 8,
  parameter int          OUTBITS    = 8,
  parameter int          COOLDOWN   = 2,
  parameter int          SETTLE     = 4,
  parameter int          RAND_COUNT = 16384,
  parameter logic [31:0] SEED       = 32'h1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         mode,
  output logic [INBITS-1:0]  comp_in,
  output logic               comp_in_valid,
  input  logic [OUTBITS-1:0] verify,
  input  logic [OUTBITS-1:0] comp_out,
  output logic               busy,
  output logic               done,
  output logic               fail,
  output logic [INBITS-1:0]  fail_vec,
  output logic [OUTBITS-1:0] fail_expected,
  output logic [OUTBITS-1:0] fail_got,
  output logic [31:0]        vec_count
);

  // One extra counter bit keeps the terminal value 2^INBITS-1 distinct from a wrap.
  localparam logic [INBITS:0]    EXH_LAST    = {1'b0, {INBITS{1'b1}}};
  localparam logic [INBITS:0]    EXH_ONE     = {{INBITS{1'b0}}, 1'b1};
  localparam logic [31:0]        RAND_LAST   = 32'(RAND_COUNT - 1);
  localparam logic [31:0]        COOL_LOAD   = (COOLDOWN > 0) ? 32'(COOLDOWN - 1) : 32'd0;
  localparam logic [31:0]        SETTLE_LOAD = 32'(SETTLE - 1);
  localparam logic [INBITS-1:0]  SEED_VEC    = SEED[INBITS-1:0];

  state_t           state;
  logic             phase_rand;  // current phase draws from the LFSR
  logic             run_both;    // exhaustive phase hands over to a random phase
  logic [INBITS:0]  exh_cnt;
  logic [INBITS:0]  exh_plus;
  logic [31:0]      lfsr;
  logic [31:0]      lfsr_next;
  logic [31:0]      rand_cnt;    // random vectors already passed in this phase
  logic [31:0]      timer;       // cycles left in the current window, minus one

  logic              mismatch;
  logic              last_exh;
  logic              enter_rand;
  logic              last_vec;
  logic [INBITS-1:0] cur_vec;
  logic [INBITS-1:0] next_vec;

  lfsr32_step u_step (
    .state      (lfsr),
    .next_state (lfsr_next)
  );

  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    exh_plus   = exh_cnt + EXH_ONE;
    cur_vec    = phase_rand ? lfsr[INBITS-1:0] : exh_cnt[INBITS-1:0];
    last_exh   = !phase_rand && (exh_cnt == EXH_LAST);
    enter_rand = last_exh && run_both;
    last_vec   = phase_rand ? (rand_cnt == RAND_LAST) : (last_exh && !run_both);
    mismatch   = (verify != comp_out);
    // Vector that follows a passing compare; only used when there is no cooldown.
    next_vec   = exh_plus[INBITS-1:0];
    if (enter_rand) begin
      next_vec = SEED_VEC;
    end else if (phase_rand) begin
      next_vec = lfsr_next[INBITS-1:0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      phase_rand    <= 1'b0;
      run_both      <= 1'b0;
      exh_cnt       <= '0;
      lfsr          <= SEED;
      rand_cnt      <= '0;
      timer         <= '0;
      comp_in       <= '0;
      comp_in_valid <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      fail          <= 1'b0;
      fail_vec      <= '0;
      fail_expected <= '0;
      fail_got      <= '0;
      vec_count     <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_FAIL: begin
          if (start) begin
            phase_rand    <= (mode == MODE_RAND);
            run_both      <= (mode == MODE_BOTH);
            exh_cnt       <= '0;
            lfsr          <= SEED;
            rand_cnt      <= '0;
            busy          <= 1'b1;
            done          <= 1'b0;
            fail          <= 1'b0;
            fail_vec      <= '0;
            fail_expected <= '0;
            fail_got      <= '0;
            vec_count     <= '0;
            if (COOLDOWN == 0) begin
              state         <= ST_SETTLE;
              timer         <= SETTLE_LOAD;
              comp_in       <= (mode == MODE_RAND) ? SEED_VEC : '0;
              comp_in_valid <= 1'b1;
            end else begin
              state         <= ST_COOL;
              timer         <= COOL_LOAD;
              comp_in       <= '0;
              comp_in_valid <= 1'b0;
            end
          end
        end

        ST_COOL: begin
          if (timer == 32'd0) begin
            state         <= ST_SETTLE;
            timer         <= SETTLE_LOAD;
            comp_in       <= cur_vec;
            comp_in_valid <= 1'b1;
          end else begin
            timer <= timer - 32'd1;
          end
        end

        ST_SETTLE: begin
          if (timer != 32'd0) begin
            timer <= timer - 32'd1;
          end else if (mismatch) begin
            fail_vec      <= comp_in;
            fail_expected <= verify;
            fail_got      <= comp_out;
            fail          <= 1'b1;
            busy          <= 1'b0;
            comp_in_valid <= 1'b0;
            state         <= ST_FAIL;
          end else begin
            if (vec_count != 32'hFFFF_FFFF) begin
              vec_count <= vec_count + 32'd1;
            end
            if (last_vec) begin
              done          <= 1'b1;
              busy          <= 1'b0;
              comp_in_valid <= 1'b0;
              state         <= ST_DONE;
            end else begin
              // The random phase always restarts from SEED, even after exhaustive.
              if (enter_rand) begin
                phase_rand <= 1'b1;
                lfsr       <= SEED;
                rand_cnt   <= '0;
              end else if (phase_rand) begin
                lfsr     <= lfsr_next;
                rand_cnt <= rand_cnt + 32'd1;
              end else begin
                exh_cnt <= exh_plus;
              end
              if (COOLDOWN == 0) begin
                timer   <= SETTLE_LOAD;
                comp_in <= next_vec;
              end else begin
                state         <= ST_COOL;
                timer         <= COOL_LOAD;
                comp_in       <= '0;
                comp_in_valid <= 1'b0;
              end
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_selftest_sequencer.sv
// Directed bench for selftest_sequencer. Two instances share clock and reset:
//   dut_a : INBITS=3, COOLDOWN=1, SETTLE=2, RAND_COUNT=4, SEED=1
//   dut_b : INBITS=3, COOLDOWN=0, SETTLE=2, RAND_COUNT=4, SEED=1
// The checked DUT/model pair is an identity function; dut_a's DUT can be made
// to flip bit 0 for input 5.
module tb_selftest_sequencer;

  localparam logic [1:0] M_EXH  = 2'b00;
  localparam logic [1:0] M_RAND = 2'b01;
  localparam logic [1:0] M_BOTH = 2'b10;
  localparam int         BOUND  = 500;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---- instance A ----
  logic        start_a = 1'b0;
  logic [1:0]  mode_a = 2'b00;
  logic        inject_a = 1'b0;
  logic [2:0]  comp_in_a, verify_a, comp_out_a, fail_vec_a, fail_exp_a, fail_got_a;
  logic        valid_a, busy_a, done_a, fail_a;
  logic [31:0] vcount_a;

  assign verify_a   = comp_in_a;
  assign comp_out_a = comp_in_a ^ {2'b00, (inject_a && comp_in_a == 3'd5)};

  selftest_sequencer #(
    .INBITS(3), .OUTBITS(3), .COOLDOWN(1), .SETTLE(2), .RAND_COUNT(4), .SEED(32'h1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .mode(mode_a),
    .comp_in(comp_in_a), .comp_in_valid(valid_a),
    .verify(verify_a), .comp_out(comp_out_a),
    .busy(busy_a), .done(done_a), .fail(fail_a),
    .fail_vec(fail_vec_a), .fail_expected(fail_exp_a), .fail_got(fail_got_a),
    .vec_count(vcount_a)
  );

  // ---- instance B ----
  logic        start_b = 1'b0;
  logic [1:0]  mode_b = 2'b00;
  logic [2:0]  comp_in_b, verify_b, comp_out_b, fail_vec_b, fail_exp_b, fail_got_b;
  logic        valid_b, busy_b, done_b, fail_b;
  logic [31:0] vcount_b;

  assign verify_b   = comp_in_b;
  assign comp_out_b = comp_in_b;

  selftest_sequencer #(
    .INBITS(3), .OUTBITS(3), .COOLDOWN(0), .SETTLE(2), .RAND_COUNT(4), .SEED(32'h1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .mode(mode_b),
    .comp_in(comp_in_b), .comp_in_valid(valid_b),
    .verify(verify_b), .comp_out(comp_out_b),
    .busy(busy_b), .done(done_b), .fail(fail_b),
    .fail_vec(fail_vec_b), .fail_expected(fail_exp_b), .fail_got(fail_got_b),
    .vec_count(vcount_b)
  );

  // Record every valid vector cycle; each vector should appear SETTLE=2 times.
  logic [2:0] q_a[$];
  logic [2:0] q_b[$];
  int         gaps_b = 0;

  always @(negedge clk) begin
    if (valid_a) q_a.push_back(comp_in_a);
    if (valid_b) q_b.push_back(comp_in_b);
    if (busy_b && !valid_b) gaps_b++;
  end

  task automatic pulse_a(input logic [1:0] m);
    @(negedge clk);
    mode_a  = m;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic pulse_b(input logic [1:0] m);
    @(negedge clk);
    mode_b  = m;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
  endtask

  // Counts falling edges after the start edge until done or fail is seen.
  task automatic wait_end_a(output int cycles);
    cycles = 0;
    while (!(done_a || fail_a) && cycles < BOUND) begin
      @(negedge clk);
      cycles++;
    end
    checks++;
    if (!(done_a || fail_a)) begin
      $display("FAIL wait_a_timeout: no done/fail after %0d cycles", cycles);
      errors++;
    end
  endtask

  task automatic wait_end_b(output int cycles);
    cycles = 0;
    while (!(done_b || fail_b) && cycles < BOUND) begin
      @(negedge clk);
      cycles++;
    end
    checks++;
    if (!(done_b || fail_b)) begin
      $display("FAIL wait_b_timeout: no done/fail after %0d cycles", cycles);
      errors++;
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({comp_in_a, valid_a, busy_a, done_a, fail_a} !== 7'd0) begin
      $display("FAIL reset_a_status: got %b want 0", {comp_in_a, valid_a, busy_a, done_a, fail_a});
      errors++;
    end
    checks++;
    if ({fail_vec_a, fail_exp_a, fail_got_a, vcount_a} !== 41'd0) begin
      $display("FAIL reset_a_results: got %h want 0", {fail_vec_a, fail_exp_a, fail_got_a, vcount_a});
      errors++;
    end
    checks++;
    if ({comp_in_b, valid_b, busy_b, done_b, fail_b, fail_vec_b, fail_exp_b, fail_got_b, vcount_b} !== 48'd0) begin
      $display("FAIL reset_b_all: got %h want 0",
               {comp_in_b, valid_b, busy_b, done_b, fail_b, fail_vec_b, fail_exp_b, fail_got_b, vcount_b});
      errors++;
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_exhaustive();
    int cyc;
    q_a.delete();
    pulse_a(M_EXH);
    wait_end_a(cyc);
    checks++;
    if (cyc !== 24) begin
      $display("FAIL exh_done_latency: got %0d want 24", cyc);
      errors++;
    end
    checks++;
    if ({done_a, fail_a, busy_a, valid_a} !== 4'b1000) begin
      $display("FAIL exh_status: got %b want 1000", {done_a, fail_a, busy_a, valid_a});
      errors++;
    end
    checks++;
    if (vcount_a !== 32'd8) begin
      $display("FAIL exh_vec_count: got %0d want 8", vcount_a);
      errors++;
    end
    checks++;
    if (q_a.size() != 16) begin
      $display("FAIL exh_seq_len: got %0d want 16", q_a.size());
      errors++;
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (q_a[2*i] !== 3'(i) || q_a[2*i+1] !== 3'(i)) begin
          $display("FAIL exh_seq[%0d]: got %0d/%0d want %0d", i, q_a[2*i], q_a[2*i+1], i);
          errors++;
        end
      end
    end
  endtask

  task automatic test_mismatch();
    int cyc;
    inject_a = 1'b1;
    pulse_a(M_EXH);
    wait_end_a(cyc);
    checks++;
    if ({fail_a, done_a, busy_a, valid_a} !== 4'b1000) begin
      $display("FAIL mm_status: got %b want 1000", {fail_a, done_a, busy_a, valid_a});
      errors++;
    end
    checks++;
    if ({fail_vec_a, fail_exp_a, fail_got_a} !== {3'd5, 3'd5, 3'd4}) begin
      $display("FAIL mm_capture: got vec=%0d exp=%0d got=%0d want 5 5 4", fail_vec_a, fail_exp_a, fail_got_a);
      errors++;
    end
    checks++;
    if (vcount_a !== 32'd5) begin
      $display("FAIL mm_vec_count: got %0d want 5", vcount_a);
      errors++;
    end
    // Results must be held while idle in FAIL.
    repeat (5) @(negedge clk);
    checks++;
    if ({fail_a, fail_vec_a, vcount_a} !== {1'b1, 3'd5, 32'd5}) begin
      $display("FAIL mm_hold: got fail=%b vec=%0d cnt=%0d want 1 5 5", fail_a, fail_vec_a, vcount_a);
      errors++;
    end
    inject_a = 1'b0;
  endtask

  task automatic test_random();
    int cyc;
    logic [2:0] exp_q[$] = '{3'd1, 3'd3, 3'd2, 3'd1};
    q_a.delete();
    pulse_a(M_RAND);
    wait_end_a(cyc);
    checks++;
    if ({done_a, fail_a, vcount_a} !== {1'b1, 1'b0, 32'd4}) begin
      $display("FAIL rand_result: got done=%b fail=%b cnt=%0d want 1 0 4", done_a, fail_a, vcount_a);
      errors++;
    end
    checks++;
    if (q_a.size() != 2 * exp_q.size()) begin
      $display("FAIL rand_seq_len: got %0d want %0d", q_a.size(), 2 * exp_q.size());
      errors++;
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (q_a[2*i] !== exp_q[i] || q_a[2*i+1] !== exp_q[i]) begin
          $display("FAIL rand_seq[%0d]: got %0d/%0d want %0d", i, q_a[2*i], q_a[2*i+1], exp_q[i]);
          errors++;
        end
      end
    end
  endtask

  task automatic test_both_no_cooldown();
    int cyc;
    logic [2:0] exp_q[$] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7,
                             3'd1, 3'd3, 3'd2, 3'd1};
    q_b.delete();
    gaps_b = 0;
    pulse_b(M_BOTH);
    wait_end_b(cyc);
    checks++;
    if (cyc !== 24) begin
      $display("FAIL both_done_latency: got %0d want 24", cyc);
      errors++;
    end
    checks++;
    if ({done_b, fail_b, vcount_b} !== {1'b1, 1'b0, 32'd12}) begin
      $display("FAIL both_result: got done=%b fail=%b cnt=%0d want 1 0 12", done_b, fail_b, vcount_b);
      errors++;
    end
    checks++;
    if (gaps_b !== 0) begin
      $display("FAIL both_valid_gaps: got %0d want 0", gaps_b);
      errors++;
    end
    checks++;
    if (q_b.size() != 2 * exp_q.size()) begin
      $display("FAIL both_seq_len: got %0d want %0d", q_b.size(), 2 * exp_q.size());
      errors++;
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (q_b[2*i] !== exp_q[i] || q_b[2*i+1] !== exp_q[i]) begin
          $display("FAIL both_seq[%0d]: got %0d/%0d want %0d", i, q_b[2*i], q_b[2*i+1], exp_q[i]);
          errors++;
        end
      end
    end
  endtask

  task automatic test_restart_and_abort();
    int cyc;
    int n;
    q_a.delete();
    pulse_a(M_EXH);
    repeat (3) @(negedge clk);
    pulse_a(M_RAND);  // busy: must be ignored
    n = 0;
    while (!(valid_a && comp_in_a == 3'd3) && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!(valid_a && comp_in_a == 3'd3)) begin
      $display("FAIL abort_reach_vec3: got valid=%b vec=%0d want 1 3", valid_a, comp_in_a);
      errors++;
    end
    checks++;
    if (q_a.size() < 6 || q_a[0] !== 3'd0 || q_a[2] !== 3'd1 || q_a[4] !== 3'd2) begin
      $display("FAIL ignore_start_seq: got size=%0d want vectors 0,1,2 in order", q_a.size());
      errors++;
    end
    checks++;
    if ({busy_a, vcount_a} !== {1'b1, 32'd3}) begin
      $display("FAIL abort_pre_count: got busy=%b cnt=%0d want 1 3", busy_a, vcount_a);
      errors++;
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({comp_in_a, valid_a, busy_a, done_a, fail_a, fail_vec_a, fail_exp_a, fail_got_a, vcount_a} !== 48'd0) begin
      $display("FAIL abort_outputs: got %h want 0",
               {comp_in_a, valid_a, busy_a, done_a, fail_a, fail_vec_a, fail_exp_a, fail_got_a, vcount_a});
      errors++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    q_a.delete();
    pulse_a(M_EXH);
    checks++;
    if ({busy_a, valid_a, comp_in_a, vcount_a} !== {1'b1, 1'b0, 3'd0, 32'd0}) begin
      $display("FAIL restart_state: got busy=%b valid=%b vec=%0d cnt=%0d want 1 0 0 0",
               busy_a, valid_a, comp_in_a, vcount_a);
      errors++;
    end
    wait_end_a(cyc);
    checks++;
    if ({done_a, vcount_a} !== {1'b1, 32'd8}) begin
      $display("FAIL restart_result: got done=%b cnt=%0d want 1 8", done_a, vcount_a);
      errors++;
    end
    checks++;
    if (q_a.size() != 16 || q_a[0] !== 3'd0 || q_a[14] !== 3'd7) begin
      $display("FAIL restart_seq: got size=%0d want 16 entries from 0 to 7", q_a.size());
      errors++;
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    inject_a = 1'b1;
    pulse_a(M_EXH);
    wait_end_a(cyc);
    checks++;
    if (fail_a !== 1'b1) begin
      $display("FAIL b2b_prefail: got %b want 1", fail_a);
      errors++;
    end
    inject_a = 1'b0;
    pulse_a(M_EXH);
    checks++;
    if ({fail_a, done_a, busy_a, fail_vec_a, fail_exp_a, fail_got_a, vcount_a} !== {3'b001, 9'd0, 32'd0}) begin
      $display("FAIL b2b_cleared: got fail=%b done=%b busy=%b fv=%0d fe=%0d fg=%0d cnt=%0d want 0 0 1 0 0 0 0",
               fail_a, done_a, busy_a, fail_vec_a, fail_exp_a, fail_got_a, vcount_a);
      errors++;
    end
    wait_end_a(cyc);
    checks++;
    if ({done_a, fail_a, vcount_a} !== {1'b1, 1'b0, 32'd8}) begin
      $display("FAIL b2b_result: got done=%b fail=%b cnt=%0d want 1 0 8", done_a, fail_a, vcount_a);
      errors++;
    end
  endtask

  initial begin
    test_reset();
    test_exhaustive();
    test_mismatch();
    test_random();
    test_both_no_cooldown();
    test_restart_and_abort();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
